// File: rtl/arbitro_pkg.sv
// rtl/arbitro_pkg.sv - shared state encodings and mode constants for arbitro_rr
package arbitro_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    POP  = 3'b010,
    PUSH = 3'b100
  } state_t;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational grant selection, fixed priority or round-robin after last
module rr_picker
  import arbitro_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic [N-1:0]  eligible,
  input  logic [SW-1:0] last,
  input  logic          mode,
  output logic [SW-1:0] grant,
  output logic          any_valid
);

  int idx;

  // Scan order starts at last+1 in round-robin, at 0 in fixed priority.
  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      if (mode == 1'(MODE_RR)) idx = (int'(last) + 1 + k) % N;
      else                     idx = k;
      if (!any_valid && eligible[idx]) begin
        any_valid = 1'b1;
        grant     = SW'(idx);
      end
    end
  end

endmodule

// File: rtl/arbitro_rr.sv
// rtl/arbitro_rr.sv - three-state arbiter moving one word per grant from NIN input FIFOs to NOUT output FIFOs
module arbitro_rr
  import arbitro_pkg::*;
#(
  parameter int NIN  = 4,
  parameter int NOUT = 4,
  parameter int MODE = 1,
  parameter int CNTW = 8,
  localparam int SW  = $clog2(NIN),
  localparam int DW  = $clog2(NOUT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NIN-1:0]    empty,
  input  logic [NIN*DW-1:0] dest,
  input  logic [NOUT-1:0]   full,
  output logic [NIN-1:0]    pop,
  output logic [NOUT-1:0]   push,
  output logic [SW-1:0]     sel,
  output logic [DW-1:0]     dsel,
  output logic              busy,
  output logic [CNTW-1:0]   xfer_cnt
);

  state_t          state;
  logic [SW-1:0]   last;
  logic [NIN-1:0]  eligible;
  logic [SW-1:0]   grant;
  logic            any_valid;
  logic [DW-1:0]   dest_i;
  logic [DW-1:0]   grant_dest;

  // An input whose destination is full is simply skipped, so it never blocks the others.
  always_comb begin
    eligible   = '0;
    grant_dest = '0;
    dest_i     = '0;
    for (int i = 0; i < NIN; i++) begin
      dest_i      = dest[i*DW +: DW];
      eligible[i] = !empty[i] && (int'(dest_i) < NOUT) && !full[dest_i];
      if (grant == SW'(i)) grant_dest = dest_i;
    end
  end

  rr_picker #(
    .N  (NIN),
    .SW (SW)
  ) u_picker (
    .eligible  (eligible),
    .last      (last),
    .mode      (1'(MODE)),
    .grant     (grant),
    .any_valid (any_valid)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      sel      <= '0;
      dsel     <= '0;
      xfer_cnt <= '0;
      last     <= SW'(NIN - 1);
    end else begin
      unique case (state)
        IDLE: begin
          if (any_valid) begin
            sel   <= grant;
            dsel  <= grant_dest;
            state <= POP;
          end
        end
        POP: state <= PUSH;
        PUSH: begin
          if (!full[dsel]) begin
            last     <= sel;
            xfer_cnt <= xfer_cnt + CNTW'(1);
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes are decoded live so reset and a late full kill them in the same cycle.
  always_comb begin
    pop  = '0;
    push = '0;
    if (reset) begin
      if (state == POP) pop[sel] = 1'b1;
      if (state == PUSH && !full[dsel]) push[dsel] = 1'b1;
    end
  end

  assign busy = (state == POP) || (state == PUSH);

endmodule

// File: tb/tb_arbitro_rr.sv
// tb/tb_arbitro_rr.sv - directed and randomized checks of a fixed-priority and a round-robin arbitro_rr
module tb_arbitro_rr;

  logic       clk;
  logic       reset;
  logic [3:0] empty_v [2];
  logic [7:0] dest_v  [2];
  logic [3:0] full_v  [2];
  logic [3:0] pop_v   [2];
  logic [3:0] push_v  [2];
  logic [1:0] sel_v   [2];
  logic [1:0] dsel_v  [2];
  logic       busy_v  [2];
  logic [1:0] cnt_fx;
  logic [7:0] cnt_rr;

  int n_cmp = 0;
  int n_err = 0;

  // Instance 0: fixed priority with a 2-bit counter; instance 1: round-robin with 8-bit counter.
  arbitro_rr #(.NIN(4), .NOUT(4), .MODE(0), .CNTW(2)) dut_fx (
    .clk(clk), .reset(reset), .empty(empty_v[0]), .dest(dest_v[0]), .full(full_v[0]),
    .pop(pop_v[0]), .push(push_v[0]), .sel(sel_v[0]), .dsel(dsel_v[0]),
    .busy(busy_v[0]), .xfer_cnt(cnt_fx)
  );

  arbitro_rr #(.NIN(4), .NOUT(4), .MODE(1), .CNTW(8)) dut_rr (
    .clk(clk), .reset(reset), .empty(empty_v[1]), .dest(dest_v[1]), .full(full_v[1]),
    .pop(pop_v[1]), .push(push_v[1]), .sel(sel_v[1]), .dsel(dsel_v[1]),
    .busy(busy_v[1]), .xfer_cnt(cnt_rr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic int dest_of(input logic [7:0] d, input int i);
    return int'((d >> (2 * i)) & 8'h3);
  endfunction

  // Reference model: one transfer at a time, phase 0 waiting, 1 popping, 2 pushing.
  int m_ph   [2];
  int m_sel  [2];
  int m_dsel [2];
  int m_last [2];
  int m_cnt  [2];
  bit m_ok = 1'b0;

  initial begin
    int mode_of [2];
    int cmod    [2];
    int e_pop, e_push, idx, act_cnt;
    bit found;
    mode_of[0] = 0; mode_of[1] = 1;
    cmod[0]    = 4; cmod[1]    = 256;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (m_ok) begin
          e_pop  = 0;
          e_push = 0;
          if (reset) begin
            if (m_ph[k] == 1) e_pop = 1 << m_sel[k];
            if (m_ph[k] == 2 && !full_v[k][m_dsel[k]]) e_push = 1 << m_dsel[k];
          end
          act_cnt = (k == 0) ? int'(cnt_fx) : int'(cnt_rr);
          check($sformatf("pop%0d", k),  int'(pop_v[k]),  e_pop);
          check($sformatf("push%0d", k), int'(push_v[k]), e_push);
          check($sformatf("busy%0d", k), int'(busy_v[k]), (m_ph[k] != 0) ? 1 : 0);
          check($sformatf("sel%0d", k),  int'(sel_v[k]),  m_sel[k]);
          check($sformatf("dsel%0d", k), int'(dsel_v[k]), m_dsel[k]);
          check($sformatf("cnt%0d", k),  act_cnt,         m_cnt[k]);
        end
        if (!reset) begin
          m_ph[k] = 0; m_sel[k] = 0; m_dsel[k] = 0; m_cnt[k] = 0; m_last[k] = 3;
        end else if (m_ph[k] == 0) begin
          found = 1'b0;
          for (int off = 0; off < 4; off++) begin
            idx = (mode_of[k] == 1) ? (m_last[k] + 1 + off) % 4 : off;
            if (!found && !empty_v[k][idx] && !full_v[k][dest_of(dest_v[k], idx)]) begin
              found     = 1'b1;
              m_sel[k]  = idx;
              m_dsel[k] = dest_of(dest_v[k], idx);
              m_ph[k]   = 1;
            end
          end
        end else if (m_ph[k] == 1) begin
          m_ph[k] = 2;
        end else if (!full_v[k][m_dsel[k]]) begin
          m_last[k] = m_sel[k];
          m_cnt[k]  = (m_cnt[k] + 1) % cmod[k];
          m_ph[k]   = 0;
        end
      end
      if (!reset) m_ok = 1'b1;
    end
  end

  initial begin
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      empty_v[k] = 4'hF; dest_v[k] = 8'h00; full_v[k] = 4'h0;
    end
    tick(); tick(); settle();
    for (int k = 0; k < 2; k++) begin
      check("rst_sel",  int'(sel_v[k]),  0);
      check("rst_dsel", int'(dsel_v[k]), 0);
      check("rst_busy", int'(busy_v[k]), 0);
      check("rst_pop",  int'(pop_v[k]),  0);
      check("rst_push", int'(push_v[k]), 0);
    end
    check("rst_cnt_fx", int'(cnt_fx), 0);
    check("rst_cnt_rr", int'(cnt_rr), 0);
    reset = 1'b1;

    // Fixed priority: inputs 1 and 3 ready, input 1 first.
    empty_v[0] = 4'b0101;
    tick(); settle();
    check("fp_pop1", int'(pop_v[0]), 4'b0010);
    check("fp_sel1", int'(sel_v[0]), 1);
    empty_v[0] = 4'b0111;
    tick(); settle();
    check("fp_push1", int'(push_v[0]), 4'b0001);
    check("fp_nopop", int'(pop_v[0]),  0);
    tick(); settle();
    check("fp_cnt1", int'(cnt_fx), 1);
    check("fp_idle", int'(busy_v[0]), 0);
    tick(); settle();
    check("fp_pop3", int'(pop_v[0]), 4'b1000);
    empty_v[0] = 4'hF;
    tick(); tick(); settle();
    check("fp_cnt2", int'(cnt_fx), 2);

    // Push stall for 4 cycles while destination 1 is full.
    empty_v[0] = 4'b1110; dest_v[0] = 8'h01;
    tick(); settle();
    check("st_pop", int'(pop_v[0]), 4'b0001);
    full_v[0] = 4'b0010; empty_v[0] = 4'hF;
    for (int c = 0; c < 4; c++) begin
      tick(); settle();
      check("st_push0", int'(push_v[0]), 0);
      check("st_busy",  int'(busy_v[0]), 1);
    end
    full_v[0] = 4'h0; settle();
    check("st_push", int'(push_v[0]), 4'b0010);
    tick(); settle();
    check("st_cnt3", int'(cnt_fx), 3);

    // Counter wrap on the 2-bit instance.
    empty_v[0] = 4'b1110; dest_v[0] = 8'h00;
    tick(); empty_v[0] = 4'hF;
    tick(); tick(); settle();
    check("wrap_cnt0", int'(cnt_fx), 0);

    // Input 0 blocked by full destination 2; input 1 served meanwhile.
    empty_v[0] = 4'b1100; dest_v[0] = 8'b0000_0110; full_v[0] = 4'b0100;
    tick(); settle();
    check("blk_sel1", int'(sel_v[0]), 1);
    check("blk_pop1", int'(pop_v[0]), 4'b0010);
    empty_v[0] = 4'b1110;
    tick(); settle();
    check("blk_push1", int'(push_v[0]), 4'b0010);
    tick(); tick(); settle();
    check("blk_wait", int'(busy_v[0]), 0);
    full_v[0] = 4'h0;
    tick(); settle();
    check("blk_sel0", int'(sel_v[0]), 0);
    check("blk_pop0", int'(pop_v[0]), 4'b0001);
    empty_v[0] = 4'hF;
    tick(); tick();

    // Round-robin fairness with all inputs persistently ready.
    empty_v[1] = 4'h0; dest_v[1] = 8'h00; full_v[1] = 4'h0;
    for (int t = 1; t <= 15; t++) begin
      tick(); settle();
      if (t % 3 == 1) check("rr_order", int'(sel_v[1]), ((t - 1) / 3) % 4);
    end
    check("rr_cnt5", int'(cnt_rr), 5);

    // Reset in the middle of a POP.
    tick(); settle();
    check("mid_sel1", int'(sel_v[1]), 1);
    reset = 1'b0; settle();
    check("mid_pop0", int'(pop_v[1]), 0);
    tick(); settle();
    check("mid_busy", int'(busy_v[1]), 0);
    check("mid_cnt",  int'(cnt_rr),    0);
    reset = 1'b1;
    tick(); settle();
    check("mid_grant0", int'(sel_v[1]), 0);
    check("mid_pop",    int'(pop_v[1]), 4'b0001);
    empty_v[1] = 4'hF;
    tick(); tick();

    // Randomized traffic, checked every cycle by the model.
    for (int c = 0; c < 3000; c++) begin
      tick();
      reset = ($urandom_range(0, 63) != 0);
      for (int k = 0; k < 2; k++) begin
        empty_v[k] = 4'($urandom);
        dest_v[k]  = 8'($urandom);
        full_v[k]  = 4'($urandom & $urandom);
      end
    end
    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
